// File: rtl/bpred_tagged_btb.sv
// Direct-mapped tagged BTB with per-entry 2-bit counters, optional gshare indexing,
// a post-reset table clearing sweep and hit/miss statistics on a debug mux.
module bpred_tagged_btb #(
    parameter int unsigned INDEX_BITS = 10,
    parameter int unsigned TAG_BITS   = 8,
    parameter int unsigned HIST_BITS  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    output logic                  ready,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    output logic [INDEX_BITS+2:0] pred_meta,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic                  update_taken,
    input  logic [31:0]           update_target,
    input  logic                  update_mispredict,
    input  logic [INDEX_BITS+2:0] update_meta,
    input  logic [1:0]            debug_sel,
    output logic [31:0]           debug_out
);

    localparam int unsigned Entries = 1 << INDEX_BITS;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [29:0]         target;
        logic [1:0]          ctr;
    } entry_t;

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic                  hit;
        logic [1:0]            ctr;
    } meta_t;

    typedef enum logic [0:0] {StInit, StRun} state_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_q, sweep_d;

    entry_t                mem [Entries];
    entry_t                rd_q;
    logic                  valid_q;
    logic [31:0]           pc_q;
    logic [INDEX_BITS-1:0] idx_q;

    logic                  running, lookup_acc, update_acc;
    logic [INDEX_BITS-1:0] hist_idx, lookup_idx;
    meta_t                 upd_meta;

    logic                  we_info, we_ctr;
    logic [INDEX_BITS-1:0] waddr;
    entry_t                wdata;
    logic                  hit;

    logic [31:0] cnt_lookup_q, cnt_update_q, cnt_mispredict_q, cnt_hit_q;
    logic [31:0] debug_q;

    assign running    = (state_q == StRun);
    assign lookup_acc = running && lookup_valid && !stall;
    assign update_acc = running && update_valid && !stall;
    assign upd_meta   = update_meta;

    // Global history is trained only by resolved updates, never speculatively.
    if (HIST_BITS > 0) begin : g_ghist
        logic [HIST_BITS-1:0] ghist_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                ghist_q <= '0;
            end else if (update_acc) begin
                ghist_q <= (ghist_q << 1) | HIST_BITS'(update_taken);
            end
        end
        assign hist_idx = INDEX_BITS'(ghist_q);
    end else begin : g_no_ghist
        assign hist_idx = '0;
    end

    assign lookup_idx = lookup_pc[INDEX_BITS+1:2] ^ hist_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            StInit: begin
                sweep_d = sweep_q + 1'b1;
                if (&sweep_q) begin
                    state_d = StRun;
                end
            end
            default: ;
        endcase
    end

    // A not-taken update only retrains the counter; the rest of the entry is left alone.
    always_comb begin
        we_info = 1'b0;
        we_ctr  = 1'b0;
        waddr   = upd_meta.index;
        wdata   = '0;
        if (!reset) begin
            if (state_q == StInit) begin
                we_info = 1'b1;
                we_ctr  = 1'b1;
                waddr   = sweep_q;
            end else if (update_acc) begin
                if (update_taken) begin
                    we_info      = 1'b1;
                    we_ctr       = 1'b1;
                    wdata.valid  = 1'b1;
                    wdata.tag    = update_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
                    wdata.target = update_target[31:2];
                    wdata.ctr    = upd_meta.hit ? sat_inc(upd_meta.ctr) : 2'b10;
                end else if (upd_meta.hit) begin
                    we_ctr    = 1'b1;
                    wdata.ctr = sat_dec(upd_meta.ctr);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we_info) begin
            mem[waddr].valid  <= wdata.valid;
            mem[waddr].tag    <= wdata.tag;
            mem[waddr].target <= wdata.target;
        end
        if (we_ctr) begin
            mem[waddr].ctr <= wdata.ctr;
        end
        if (!stall) begin
            rd_q <= mem[lookup_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            idx_q   <= '0;
        end else if (!stall) begin
            valid_q <= lookup_acc;
            pc_q    <= lookup_pc;
            idx_q   <= lookup_idx;
        end
    end

    assign hit         = rd_q.valid && (rd_q.tag == pc_q[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]);
    assign ready       = running;
    assign pred_valid  = valid_q;
    assign pred_taken  = valid_q && hit && rd_q.ctr[1];
    assign pred_target = !valid_q  ? 32'd0 :
                         pred_taken ? {rd_q.target, 2'b00} : pc_q + 32'd4;
    assign pred_meta   = valid_q ? {idx_q, hit, rd_q.ctr} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_lookup_q     <= '0;
            cnt_update_q     <= '0;
            cnt_mispredict_q <= '0;
            cnt_hit_q        <= '0;
            debug_q          <= '0;
        end else begin
            if (lookup_acc) cnt_lookup_q <= cnt_lookup_q + 32'd1;
            if (update_acc) cnt_update_q <= cnt_update_q + 32'd1;
            if (update_acc && update_mispredict) cnt_mispredict_q <= cnt_mispredict_q + 32'd1;
            if (update_acc && upd_meta.hit) cnt_hit_q <= cnt_hit_q + 32'd1;
            unique case (debug_sel)
                2'b00: debug_q <= cnt_lookup_q;
                2'b01: debug_q <= cnt_update_q;
                2'b10: debug_q <= cnt_mispredict_q;
                2'b11: debug_q <= cnt_hit_q;
            endcase
        end
    end

    assign debug_out = debug_q;

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], update_pc, update_target[1:0], pc_q};

endmodule

// File: tb/tb_bpred_tagged_btb.sv
// Bench for bpred_tagged_btb: table-level reference model checked every cycle, plus
// directed literal checks; a small gshare instance covers history indexing.
module tb_bpred_tagged_btb;

    localparam int IB = 10;
    localparam int TB = 8;
    localparam int MW = IB + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, stall, ready;
    logic          lookup_valid, pred_valid, pred_taken;
    logic [31:0]   lookup_pc, pred_target;
    logic [MW-1:0] pred_meta, update_meta;
    logic          update_valid, update_taken, update_mispredict;
    logic [31:0]   update_pc, update_target, debug_out;
    logic [1:0]    debug_sel;

    logic          h_stall, h_ready, h_lookup_valid, h_pred_valid, h_pred_taken;
    logic [31:0]   h_lookup_pc, h_pred_target, h_update_pc, h_update_target, h_debug_out;
    logic [6:0]    h_pred_meta, h_update_meta;
    logic          h_update_valid, h_update_taken, h_update_mispredict;
    logic [1:0]    h_debug_sel;

    bpred_tagged_btb dut (
        .clk(clk), .reset(reset), .stall(stall), .ready(ready),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_meta(pred_meta), .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_target(update_target),
        .update_mispredict(update_mispredict), .update_meta(update_meta),
        .debug_sel(debug_sel), .debug_out(debug_out)
    );

    bpred_tagged_btb #(.INDEX_BITS(4), .TAG_BITS(8), .HIST_BITS(4)) dut_h (
        .clk(clk), .reset(reset), .stall(h_stall), .ready(h_ready),
        .lookup_valid(h_lookup_valid), .lookup_pc(h_lookup_pc),
        .pred_valid(h_pred_valid), .pred_taken(h_pred_taken), .pred_target(h_pred_target),
        .pred_meta(h_pred_meta), .update_valid(h_update_valid), .update_pc(h_update_pc),
        .update_taken(h_update_taken), .update_target(h_update_target),
        .update_mispredict(h_update_mispredict), .update_meta(h_update_meta),
        .debug_sel(h_debug_sel), .debug_out(h_debug_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the table as plain arrays plus the four statistics.
    logic          m_v   [1 << IB];
    logic [TB-1:0] m_tag [1 << IB];
    logic [29:0]   m_tgt [1 << IB];
    logic [1:0]    m_ctr [1 << IB];
    int            init_left = 0;
    logic          model_on = 1'b0;
    logic          exp_ready = 1'b0, exp_valid = 1'b0, exp_taken = 1'b0;
    logic [31:0]   exp_target = '0, exp_dbg = '0;
    logic [MW-1:0] exp_meta = '0;
    logic [31:0]   n_lk = '0, n_up = '0, n_mp = '0, n_hit = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic [IB-1:0] idx;
        logic          h;
        logic [1:0]    c;
        if (reset) begin
            init_left = 1 << IB;
            for (int i = 0; i < (1 << IB); i++) begin
                m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = '0;
            end
            exp_valid = 1'b0; exp_taken = 1'b0; exp_target = '0; exp_meta = '0;
            exp_dbg = '0; n_lk = '0; n_up = '0; n_mp = '0; n_hit = '0;
            model_on = 1'b1;
        end else begin
            case (debug_sel)
                2'b00:   exp_dbg = n_lk;
                2'b01:   exp_dbg = n_up;
                2'b10:   exp_dbg = n_mp;
                default: exp_dbg = n_hit;
            endcase
            if (init_left > 0) begin
                init_left--;
                if (!stall) exp_valid = 1'b0;
            end else if (!stall) begin
                if (lookup_valid) begin
                    idx = lookup_pc[IB+1:2];
                    h = m_v[idx] && (m_tag[idx] == lookup_pc[IB+TB+1:IB+2]);
                    exp_valid  = 1'b1;
                    exp_taken  = h && m_ctr[idx][1];
                    exp_target = exp_taken ? {m_tgt[idx], 2'b00} : lookup_pc + 32'd4;
                    exp_meta   = {idx, h, m_ctr[idx]};
                    n_lk = n_lk + 32'd1;
                end else begin
                    exp_valid = 1'b0;
                end
                if (update_valid) begin
                    idx = update_meta[MW-1:3];
                    h   = update_meta[2];
                    c   = update_meta[1:0];
                    if (update_taken) begin
                        m_v[idx]   = 1'b1;
                        m_tag[idx] = update_pc[IB+TB+1:IB+2];
                        m_tgt[idx] = update_target[31:2];
                        m_ctr[idx] = !h ? 2'b10 : (c == 2'b11) ? 2'b11 : c + 2'b01;
                    end else if (h) begin
                        m_ctr[idx] = (c == 2'b00) ? 2'b00 : c - 2'b01;
                    end
                    n_up = n_up + 32'd1;
                    if (update_mispredict) n_mp = n_mp + 32'd1;
                    if (h) n_hit = n_hit + 32'd1;
                end
            end
        end
        exp_ready = (init_left == 0);
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_ready", 32'(ready), 32'(exp_ready));
            chk("model_pred_valid", 32'(pred_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("model_pred_taken", 32'(pred_taken), 32'(exp_taken));
                chk("model_pred_target", pred_target, exp_target);
                chk("model_pred_meta", 32'(pred_meta), 32'(exp_meta));
            end
            chk("model_debug_out", debug_out, exp_dbg);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'd1024);
    endtask

    task automatic set_update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                              input logic mis, input logic [MW-1:0] meta);
        update_valid = 1'b1; update_pc = pc; update_taken = t;
        update_target = tgt; update_mispredict = mis; update_meta = meta;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        tick();
        lookup_valid = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic chk_pred(input string name, input logic t, input logic [31:0] tgt,
                            input logic [MW-1:0] meta);
        chk({name, "_valid"}, 32'(pred_valid), 32'd1);
        chk({name, "_taken"}, 32'(pred_taken), 32'(t));
        chk({name, "_target"}, pred_target, tgt);
        chk({name, "_meta"}, 32'(pred_meta), 32'(meta));
    endtask

    int nt_in[4]  = '{6, 5, 4, 4};
    int nt_out[4] = '{5, 4, 4, 4};
    int dbg_lit[4] = '{10, 6, 3, 4};

    initial begin
        reset = 1'b1; stall = 1'b0; debug_sel = 2'b00;
        lookup_valid = 1'b0; lookup_pc = '0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
        update_target = '0; update_mispredict = 1'b0; update_meta = '0;
        h_stall = 1'b0; h_lookup_valid = 1'b0; h_lookup_pc = '0; h_update_valid = 1'b0;
        h_update_pc = '0; h_update_taken = 1'b0; h_update_target = 32'h100;
        h_update_mispredict = 1'b0; h_update_meta = '0; h_debug_sel = 2'b01;

        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_target", pred_target, 32'd0);
        chk("rst_pred_meta", 32'(pred_meta), 32'd0);
        chk("rst_debug_out", debug_out, 32'd0);

        reset = 1'b0;
        wait_ready("ready_latency");

        // Gshare instance: history T,T,N,T gives 1101 and steers PC 0 to index 13.
        chk("h_ready", 32'(h_ready), 32'd1);
        h_update_valid = 1'b1;
        h_update_taken = 1'b1; tick();
        h_update_taken = 1'b1; tick();
        h_update_taken = 1'b0; tick();
        h_update_taken = 1'b1; tick();
        h_update_valid = 1'b0;
        h_lookup_valid = 1'b1; tick();
        h_lookup_valid = 1'b0;
        chk("h_pred_valid", 32'(h_pred_valid), 32'd1);
        chk("h_index", 32'(h_pred_meta[6:3]), 32'd13);
        chk("h_hit", 32'(h_pred_meta[2]), 32'd0);
        chk("h_pred_target", h_pred_target, 32'h4);
        chk("h_updates", h_debug_out, 32'd4);

        do_lookup(32'h1000);
        chk_pred("cold", 1'b0, 32'h1004, MW'(0));

        set_update(32'h1000, 1'b1, 32'h2000, 1'b1, MW'(0));
        tick();
        update_valid = 1'b0;
        do_lookup(32'h1000);
        chk_pred("trained", 1'b1, 32'h2000, MW'(6));

        do_lookup(32'h0008_1000);
        chk_pred("alias", 1'b0, 32'h0008_1004, MW'(2));

        for (int i = 0; i < 4; i++) begin
            set_update(32'h1000, 1'b0, 32'h2000, (i == 0), MW'(nt_in[i]));
            tick();
            update_valid = 1'b0;
            do_lookup(32'h1000);
            chk_pred("nt_decay", 1'b0, 32'h1004, MW'(nt_out[i]));
        end

        set_update(32'h1000, 1'b1, 32'h3000, 1'b1, MW'(0));
        do_lookup(32'h1000);
        chk_pred("same_cycle_old", 1'b0, 32'h1004, MW'(4));
        lookup_valid = 1'b1;
        tick();
        chk_pred("same_cycle_new", 1'b1, 32'h3000, MW'(6));

        stall = 1'b1;
        lookup_pc = 32'h5000;
        set_update(32'h1000, 1'b1, 32'h4000, 1'b0, MW'(6));
        tick();
        tick();
        chk_pred("stall_hold", 1'b1, 32'h3000, MW'(6));
        stall = 1'b0;
        update_valid = 1'b0;
        do_lookup(32'h1000);
        chk_pred("stall_no_write", 1'b1, 32'h3000, MW'(6));

        for (int s = 0; s < 4; s++) begin
            debug_sel = 2'(s);
            tick();
            tick();
            chk("debug_count", debug_out, 32'(dbg_lit[s]));
        end

        reset = 1'b1;
        tick();
        chk("midrun_ready", 32'(ready), 32'd0);
        chk("midrun_pred_valid", 32'(pred_valid), 32'd0);
        chk("midrun_pred_target", pred_target, 32'd0);
        chk("midrun_pred_meta", 32'(pred_meta), 32'd0);
        chk("midrun_debug_out", debug_out, 32'd0);
        reset = 1'b0;
        repeat (500) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready("ready_after_resweep");

        for (int s = 0; s < 4; s++) begin
            debug_sel = 2'(s);
            tick();
            chk("debug_cleared", debug_out, 32'd0);
        end

        do_lookup(32'h1000);
        chk_pred("cleared_table", 1'b0, 32'h1004, MW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
